// File: rtl/vehicle_plant_if.sv
// Signal bundle between the cruise controller and the vehicle/driver plant.
// Commands and driver activity flow into the plant; measured speed, alertness and status flow out.
interface vehicle_plant_if;
  logic [7:0] target;
  logic       tormoz;
  logic       driver_act;
  logic [7:0] speed;
  logic [2:0] hooshyari;
  logic [1:0] state;
  logic       tick;
  logic       at_target;

  modport master (
    output target, tormoz, driver_act,
    input  speed, hooshyari, state, tick, at_target
  );

  modport slave (
    input  target, tormoz, driver_act,
    output speed, hooshyari, state, tick, at_target
  );
endinterface

// File: rtl/vehicle_plant.sv
// Vehicle speed plant (prescaled accel/coast/brake FSM) plus a driver alertness decay model.
// Closes the loop around the cruise controller in system simulation and demos.
module vehicle_plant #(
  parameter int INIT_SPEED    = 200,
  parameter int MAX_SPEED     = 250,
  parameter int ACCEL_STEP    = 2,
  parameter int COAST_STEP    = 1,
  parameter int BRAKE_STEP    = 8,
  parameter int TICK_DIV      = 4,
  parameter int DROWSY_CYCLES = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  vehicle_plant_if.slave  bus
);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    ACCEL = 2'd1,
    COAST = 2'd2,
    BRAKE = 2'd3
  } state_e;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DROWSY_CYCLES > 1) ? $clog2(DROWSY_CYCLES) : 1;
  localparam logic [7:0]    MAX_V     = 8'(MAX_SPEED);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DROWSY_CYCLES - 1);

  state_e        state_q, state_d;
  logic [7:0]    speed_q, speed_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [2:0]    hoosh_q, hoosh_d;
  logic [7:0]    eff_target;
  logic          tick;
  logic [8:0]    accel_v;
  logic signed [9:0] coast_v;
  logic signed [9:0] brake_v;

  // Upward step limited to the target so ACCEL never overshoots.
  function automatic logic [7:0] clamp_hi(input logic [8:0] v, input logic [7:0] hi);
    return (v > {1'b0, hi}) ? hi : v[7:0];
  endfunction

  // Downward step limited to a floor (target for COAST, zero for BRAKE).
  function automatic logic [7:0] clamp_lo(input logic signed [9:0] v, input logic [7:0] lo);
    return (v < $signed({2'b00, lo})) ? lo : v[7:0];
  endfunction

  assign eff_target = (bus.target > MAX_V) ? MAX_V : bus.target;
  assign tick       = (pcnt_q == TICK_LAST);
  assign pcnt_d     = tick ? '0 : pcnt_q + PW'(1);

  assign accel_v = {1'b0, speed_q} + 9'(ACCEL_STEP);
  assign coast_v = $signed({2'b00, speed_q}) - $signed(10'(COAST_STEP));
  assign brake_v = $signed({2'b00, speed_q}) - $signed(10'(BRAKE_STEP));

  // Next state and speed; the speed action follows the state being entered.
  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    if (tick) begin
      if (bus.tormoz)                 state_d = BRAKE;
      else if (speed_q < eff_target)  state_d = ACCEL;
      else if (speed_q > eff_target)  state_d = COAST;
      else                            state_d = HOLD;
      case (state_d)
        ACCEL:   speed_d = clamp_hi(accel_v, eff_target);
        COAST:   speed_d = clamp_lo(coast_v, eff_target);
        BRAKE:   speed_d = clamp_lo(brake_v, 8'd0);
        default: speed_d = speed_q;
      endcase
    end
  end

  always_comb begin
    hoosh_d = hoosh_q;
    dcnt_d  = dcnt_q + DW'(1);
    if (bus.driver_act) begin
      hoosh_d = 3'd7;
      dcnt_d  = '0;
    end else if (dcnt_q == DCNT_LAST) begin
      dcnt_d  = '0;
      hoosh_d = (hoosh_q == 3'd0) ? 3'd0 : hoosh_q - 3'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= HOLD;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      speed_q <= 8'(INIT_SPEED);
      pcnt_q  <= '0;
      dcnt_q  <= '0;
      hoosh_q <= 3'd7;
    end else begin
      speed_q <= speed_d;
      pcnt_q  <= pcnt_d;
      dcnt_q  <= dcnt_d;
      hoosh_q <= hoosh_d;
    end
  end

  assign bus.speed     = speed_q;
  assign bus.state     = state_q;
  assign bus.hooshyari = hoosh_q;
  assign bus.tick      = tick;
  assign bus.at_target = (speed_q == eff_target);

endmodule

// File: tb/tb_vehicle_plant.sv
// Bench for vehicle_plant: directed scenarios with literal expectations plus a
// per-cycle comparison against a behavioural model of the plant and driver.
module tb_vehicle_plant;

  localparam int TICK_DIV = 4;
  localparam int DROWSY   = 16;
  localparam int MAXS     = 250;
  localparam int INIT     = 200;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  vehicle_plant_if bus();

  vehicle_plant #(
    .INIT_SPEED(INIT), .MAX_SPEED(MAXS), .ACCEL_STEP(2), .COAST_STEP(1),
    .BRAKE_STEP(8), .TICK_DIV(TICK_DIV), .DROWSY_CYCLES(DROWSY)
  ) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: speed rules per tick, alertness from the idle run length.
  function automatic int f_eff(input int t);
    return (t > MAXS) ? MAXS : t;
  endfunction

  function automatic int f_next_state(input int sp, input int t, input bit tz);
    if (tz)               return 3;
    if (sp < f_eff(t))    return 1;
    if (sp > f_eff(t))    return 2;
    return 0;
  endfunction

  function automatic int f_next_speed(input int sp, input int t, input bit tz);
    int e;
    e = f_eff(t);
    if (tz)      return (sp - 8 < 0) ? 0 : sp - 8;
    if (sp < e)  return (sp + 2 > e) ? e : sp + 2;
    if (sp > e)  return (sp - 1 < e) ? e : sp - 1;
    return sp;
  endfunction

  function automatic int f_alert(input int idle);
    return (idle / DROWSY >= 7) ? 0 : 7 - idle / DROWSY;
  endfunction

  int m_speed = INIT;
  int m_state = 0;
  int m_n     = 0;
  int m_idle  = 0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_speed <= INIT;
      m_state <= 0;
      m_n     <= 0;
      m_idle  <= 0;
    end else begin
      if (m_n % TICK_DIV == TICK_DIV - 1) begin
        m_speed <= f_next_speed(m_speed, int'(bus.target), bus.tormoz);
        m_state <= f_next_state(m_speed, int'(bus.target), bus.tormoz);
      end
      m_n    <= m_n + 1;
      m_idle <= bus.driver_act ? 0 : m_idle + 1;
    end
  end

  always @(negedge clock) begin
    if (cmp_on) begin
      chk("mdl_speed", int'(bus.speed), m_speed);
      chk("mdl_state", int'(bus.state), m_state);
      chk("mdl_alert", int'(bus.hooshyari), f_alert(m_idle));
      chk("mdl_tick", int'(bus.tick), (m_n % TICK_DIV == TICK_DIV - 1) ? 1 : 0);
      chk("mdl_at_target", int'(bus.at_target), (m_speed == f_eff(int'(bus.target))) ? 1 : 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Advance through the next plant update edge; a missing tick counts as a failure.
  task automatic step_tick();
    int k;
    k = 0;
    while (bus.tick !== 1'b1 && k < 2 * TICK_DIV) begin
      cyc(1);
      k++;
    end
    if (bus.tick !== 1'b1) begin
      chk("tick_timeout", 0, 1);
    end else begin
      cyc(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int bv[4];
    bv = '{12, 4, 0, 0};
    bus.target     = 8'd200;
    bus.tormoz     = 1'b0;
    bus.driver_act = 1'b1;

    #1 reset_n = 1'b0;
    cmp_on = 1'b1;
    #2;
    chk("rst_speed", int'(bus.speed), 200);
    chk("rst_alert", int'(bus.hooshyari), 7);
    chk("rst_state", int'(bus.state), 0);
    chk("rst_tick", int'(bus.tick), 0);
    chk("rst_at_target", int'(bus.at_target), 1);

    cyc(2);
    reset_n = 1'b1;
    bus.target = 8'd210;
    cyc(3);
    chk("first_tick_high", int'(bus.tick), 1);
    chk("pre_tick_speed", int'(bus.speed), 200);
    cyc(1);
    chk("ramp_202", int'(bus.speed), 202);
    chk("ramp_state", int'(bus.state), 1);
    chk("post_tick_low", int'(bus.tick), 0);
    for (int v = 204; v <= 210; v += 2) begin
      step_tick();
      chk("ramp_speed", int'(bus.speed), v);
      chk("ramp_state", int'(bus.state), 1);
    end
    step_tick();
    chk("ramp_hold_state", int'(bus.state), 0);
    chk("ramp_hold_speed", int'(bus.speed), 210);
    chk("ramp_at_target", int'(bus.at_target), 1);

    bus.target = 8'd230;
    step_tick();
    chk("ramp2_212", int'(bus.speed), 212);
    step_tick();
    chk("ramp2_214", int'(bus.speed), 214);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_speed", int'(bus.speed), 200);
    chk("midrst_state", int'(bus.state), 0);
    chk("midrst_alert", int'(bus.hooshyari), 7);
    chk("midrst_tick", int'(bus.tick), 0);

    @(posedge clock);
    #1;
    reset_n = 1'b1;
    bus.target = 8'd195;
    for (int v = 199; v >= 195; v--) begin
      step_tick();
      chk("coast_speed", int'(bus.speed), v);
      chk("coast_state", int'(bus.state), 2);
    end
    step_tick();
    chk("coast_hold_state", int'(bus.state), 0);
    chk("coast_at_target", int'(bus.at_target), 1);

    bus.tormoz = 1'b1;
    repeat (21) step_tick();
    chk("brake_27", int'(bus.speed), 27);
    chk("brake_state", int'(bus.state), 3);
    bus.tormoz = 1'b0;
    bus.target = 8'd20;
    for (int i = 0; i < 30 && bus.speed != 8'd20; i++) step_tick();
    chk("settle_20", int'(bus.speed), 20);

    bus.target = 8'd100;
    bus.tormoz = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step_tick();
      chk("brake_low_speed", int'(bus.speed), bv[i]);
      chk("brake_low_state", int'(bus.state), 3);
    end
    bus.tormoz = 1'b0;
    step_tick();
    chk("release_2", int'(bus.speed), 2);
    chk("release_state", int'(bus.state), 1);
    step_tick();
    chk("release_4", int'(bus.speed), 4);

    bus.target = 8'd248;
    for (int i = 0; i < 200 && bus.speed != 8'd248; i++) step_tick();
    chk("reach_248", int'(bus.speed), 248);
    bus.target = 8'd255;
    step_tick();
    chk("cap_250", int'(bus.speed), 250);
    chk("cap_state", int'(bus.state), 1);
    step_tick();
    chk("cap_hold_speed", int'(bus.speed), 250);
    chk("cap_hold_state", int'(bus.state), 0);
    chk("cap_at_target", int'(bus.at_target), 1);
    repeat (3) step_tick();
    chk("cap_stays_250", int'(bus.speed), 250);

    bus.driver_act = 1'b0;
    cyc(48);
    chk("alert_48", int'(bus.hooshyari), 4);
    bus.driver_act = 1'b1;
    cyc(1);
    chk("alert_pulse", int'(bus.hooshyari), 7);
    bus.driver_act = 1'b0;
    cyc(112);
    chk("alert_112", int'(bus.hooshyari), 0);
    cyc(20);
    chk("alert_floor", int'(bus.hooshyari), 0);
    bus.driver_act = 1'b1;
    cyc(1);
    bus.driver_act = 1'b0;
    cyc(15);
    chk("alert_pre_decay", int'(bus.hooshyari), 7);
    bus.driver_act = 1'b1;
    cyc(1);
    chk("alert_act_wins", int'(bus.hooshyari), 7);
    bus.driver_act = 1'b0;
    cyc(15);
    chk("alert_restart", int'(bus.hooshyari), 7);
    cyc(1);
    chk("alert_restart_dec", int'(bus.hooshyari), 6);

    cmp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
